mips_multicycle_controller: RTL and testbench

Finite-state controller that sequences a shared-resource multicycle MIPS datapath: one ALU, one unified instruction/data memory and one register file, reused across cycles. It decodes `op`/`funct` from the instruction register and emits per-cycle mux selects, write strobes and ALU control. It supports LW, SW, R-type (ADD/SUB/AND/OR/SLT), BEQ, ADDI and optionally J. It also stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/mips_multicycle_controller.sv | 206 ++++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller.sv
// ============================================================================
// Module   : mips_multicycle_controller
// Purpose  : Multicycle MIPS control FSM with memory-ready stalls and a
//            retired-instruction counter. Define MCCTRL_JUMP_EN to add J.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 memready,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic                 pcen,
    output logic [2:0]           alucontrol,
    output logic                 illegal,
    output logic [3:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
`ifdef MCCTRL_JUMP_EN
    localparam logic [5:0] c_OP_J     = 6'b000010;
`endif

    state_t               r_state;
    state_t               w_next;
    logic [INSTRET_W-1:0] r_instret;
    logic                 w_retire;
    logic                 w_pcwrite;
    logic                 w_branch;
    logic [1:0]           w_aluop;
    logic                 w_irwrite;
    logic                 w_memwrite;
    logic                 w_regwrite;
    logic                 w_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_retire   = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = 2'b00;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = memready;
                w_pcwrite = memready;
                w_next    = memready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEX;
`ifdef MCCTRL_JUMP_EN
                    c_OP_J:           w_next = S_JUMP;
`endif
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = memready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
                w_next     = memready ? S_FETCH : S_MEMWR;
                w_retire   = memready;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                w_aluop = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                w_aluop  = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
                w_retire = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
`ifdef MCCTRL_JUMP_EN
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_retire  = 1'b1;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (w_aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Strobes are squashed during reset so an aborted access cannot commit.
    assign irwrite  = w_irwrite  & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign illegal  = w_illegal  & ~reset;
    assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;
    assign state    = r_state;
    assign instret  = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_controller.sv
// ============================================================================
// Module   : tb_mips_multicycle_controller
// Purpose  : Instruction-level reference model with random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_controller;

    localparam int W = 4;
`ifdef MCCTRL_JUMP_EN
    localparam bit c_JUMP_EN = 1'b1;
`else
    localparam bit c_JUMP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [5:0]   op = 6'd0;
    logic [5:0]   funct = 6'd0;
    logic         zero = 1'b0;
    logic         memready = 1'b0;
    logic         iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]   alusrcb, pcsrc;
    logic         pcen, illegal;
    logic [2:0]   alucontrol;
    logic [3:0]   state;
    logic [W-1:0] instret;

    mips_multicycle_controller #(.INSTRET_W(W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memready(memready), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol),
        .illegal(illegal), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic         chk_en = 1'b0;
    logic [W-1:0] model_instret = '0;

    logic [3:0]   e_state;
    logic [W-1:0] e_instret;
    logic         e_iord, e_memwrite, e_irwrite, e_regdst, e_memtoreg;
    logic         e_regwrite, e_alusrca, e_pcen, e_illegal;
    logic [1:0]   e_alusrcb, e_pcsrc;
    logic [2:0]   e_aluctl;

    localparam logic [5:0] c_LW = 6'b100011, c_SW = 6'b101011, c_R = 6'b000000;
    localparam logic [5:0] c_BEQ = 6'b000100, c_ADDI = 6'b001000, c_J = 6'b000010;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state), 32'(e_state));
            check("instret", 32'(instret), 32'(e_instret));
            check("iord", 32'(iord), 32'(e_iord));
            check("memwrite", 32'(memwrite), 32'(e_memwrite));
            check("irwrite", 32'(irwrite), 32'(e_irwrite));
            check("regdst", 32'(regdst), 32'(e_regdst));
            check("memtoreg", 32'(memtoreg), 32'(e_memtoreg));
            check("regwrite", 32'(regwrite), 32'(e_regwrite));
            check("alusrca", 32'(alusrca), 32'(e_alusrca));
            check("alusrcb", 32'(alusrcb), 32'(e_alusrcb));
            check("pcsrc", 32'(pcsrc), 32'(e_pcsrc));
            check("pcen", 32'(pcen), 32'(e_pcen));
            check("alucontrol", 32'(alucontrol), 32'(e_aluctl));
            check("illegal", 32'(illegal), 32'(e_illegal));
        end
    end

    function automatic logic [2:0] alu_ref(input logic [1:0] aop, input logic [5:0] f);
        if (aop == 2'b01) return 3'b110;
        if (aop != 2'b10) return 3'b010;
        case (f)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h2A: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return (o == c_LW) || (o == c_SW) || (o == c_R) || (o == c_BEQ) ||
               (o == c_ADDI) || (c_JUMP_EN && o == c_J);
    endfunction

    // One cycle in the given phase: set inputs, publish expectations, advance.
    task automatic drive(input int st, input logic rst, input logic mr);
        logic pcw, br;
        logic [1:0] aop;
        reset = rst; memready = mr;
        pcw = 1'b0; br = 1'b0; aop = 2'b00;
        e_state = 4'(st); e_instret = model_instret;
        e_iord = 0; e_memwrite = 0; e_irwrite = 0; e_regdst = 0; e_memtoreg = 0;
        e_regwrite = 0; e_alusrca = 0; e_alusrcb = 2'b00; e_pcsrc = 2'b00; e_illegal = 0;
        case (st)
            0: begin e_alusrcb = 2'b01; e_irwrite = mr; pcw = mr; end
            1: begin e_alusrcb = 2'b11; e_illegal = !is_legal(op); end
            2: begin e_alusrca = 1; e_alusrcb = 2'b10; end
            3: e_iord = 1;
            4: begin e_memtoreg = 1; e_regwrite = 1; end
            5: begin e_iord = 1; e_memwrite = 1; end
            6: begin e_alusrca = 1; aop = 2'b10; end
            7: begin e_regdst = 1; e_regwrite = 1; end
            8: begin e_alusrca = 1; aop = 2'b01; e_pcsrc = 2'b01; br = 1; end
            9: begin e_alusrca = 1; e_alusrcb = 2'b10; end
            10: e_regwrite = 1;
            11: begin e_pcsrc = 2'b10; pcw = 1; end
            default: ;
        endcase
        e_aluctl = alu_ref(aop, funct);
        e_pcen = pcw | (br & zero);
        if (rst) begin
            e_irwrite = 0; e_pcen = 0; e_memwrite = 0; e_regwrite = 0; e_illegal = 0;
        end
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Whole instruction: fs/ms low-memready cycles in FETCH / memory phase;
    // ab asserts reset in the first memory-phase cycle instead of finishing.
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int fs, input int ms, input logic ab);
        int mst;
        op = o; funct = f; zero = z;
        repeat (fs) drive(0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'($urandom_range(0, 1)));
        if (o == c_LW || o == c_SW) begin
            mst = (o == c_LW) ? 3 : 5;
            drive(2, 1'b0, 1'($urandom_range(0, 1)));
            if (ab) begin
                drive(mst, 1'b1, 1'b0);
                model_instret = '0;
                return;
            end
            repeat (ms) drive(mst, 1'b0, 1'b0);
            drive(mst, 1'b0, 1'b1);
            if (o == c_LW) drive(4, 1'b0, 1'($urandom_range(0, 1)));
            model_instret++;
        end else if (o == c_R) begin
            drive(6, 1'b0, 1'b0); drive(7, 1'b0, 1'b1); model_instret++;
        end else if (o == c_BEQ) begin
            drive(8, 1'b0, 1'($urandom_range(0, 1))); model_instret++;
        end else if (o == c_ADDI) begin
            drive(9, 1'b0, 1'b1); drive(10, 1'b0, 1'b0); model_instret++;
        end else if (c_JUMP_EN && o == c_J) begin
            drive(11, 1'b0, 1'b0); model_instret++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] functs [6];
        logic [5:0] o, f;
        int k;
        functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
        functs[3] = 6'h25; functs[4] = 6'h2A; functs[5] = 6'h3F;

        reset = 1'b1; memready = 1'b1;
        @(posedge clk); #1;
        model_instret = '0;
        drive(0, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_instret", 32'(instret), 32'd0);

        do_instr(c_LW, 6'h00, 1'b0, 0, 0, 1'b0);
        check("lw_instret", 32'(instret), 32'd1);
        do_instr(c_SW, 6'h00, 1'b0, 0, 2, 1'b0);
        check("sw_instret", 32'(instret), 32'd2);
        do_instr(c_R, 6'h2A, 1'b0, 1, 0, 1'b0);
        do_instr(c_BEQ, 6'h00, 1'b1, 0, 0, 1'b0);
        do_instr(c_BEQ, 6'h00, 1'b0, 0, 0, 1'b0);
        check("beq_instret", 32'(instret), 32'd5);
        do_instr(6'b111111, 6'h00, 1'b0, 0, 0, 1'b0);
        check("illegal_instret", 32'(instret), 32'd5);
        do_instr(c_J, 6'h00, 1'b0, 0, 0, 1'b0);
        check("j_instret", 32'(instret), c_JUMP_EN ? 32'd6 : 32'd5);

        do_instr(c_LW, 6'h00, 1'b0, 0, 1, 1'b1);
        check("abort_state", 32'(state), 32'd0);
        check("abort_instret", 32'(instret), 32'd0);
        do_instr(c_SW, 6'h00, 1'b0, 0, 0, 1'b1);
        check("abort_sw_instret", 32'(instret), 32'd0);

        while (model_instret != 4'hF) do_instr(c_ADDI, 6'h00, 1'b0, 0, 0, 1'b0);
        check("preset_instret", 32'(instret), 32'd15);
        do_instr(c_ADDI, 6'h00, 1'b0, 0, 0, 1'b0);
        check("wrap_instret", 32'(instret), 32'd0);

        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 7));
            f = functs[$urandom_range(0, 5)];
            case (k)
                0: o = c_LW;
                1: o = c_SW;
                2, 7: o = c_R;
                3: o = c_BEQ;
                4: o = c_ADDI;
                5: o = c_J;
                default: o = 6'($urandom_range(0, 63));
            endcase
            if (k == 7) f = 6'($urandom_range(0, 63));
            do_instr(o, f, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 29) == 0));
        end
        drive(0, 1'b0, 1'b0);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
